// File: rtl/fir_buf_sequencer.sv
// fir_buf_sequencer: writes incoming samples into a circular dual-port sample
// RAM. Once TAPS samples have been stored, each new write is followed by a
// read pass that walks the newest TAPS samples from oldest to newest, with
// the matching coefficient index alongside.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   wrt_smpl, new_smpl  single-cycle sample-store request and its data
//   mem_we/waddr/wdata  RAM write port
//   mem_raddr           RAM read address of the current tap
//   coef_addr           coefficient index of the current tap
//   sequencing          mem_raddr/coef_addr carry a valid tap
//   first_tap/last_tap  first/last tap of a pass
//   primed              TAPS samples written since reset
//   overrun             sticky: a sample was dropped
//
// Build option: define SEQ_SKID_EN to hold one colliding sample in a skid
// register instead of dropping it.
module fir_buf_sequencer #(
  parameter int unsigned DEPTH = 1536,
  parameter int unsigned TAPS  = 1021,
  parameter int unsigned AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrt_smpl,
  input  logic [15:0]   new_smpl,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [15:0]   mem_wdata,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] coef_addr,
  output logic          sequencing,
  output logic          first_tap,
  output logic          last_tap,
  output logic          primed,
  output logic          overrun
);

  localparam int unsigned FW = $clog2(TAPS + 1);
  localparam int unsigned XW = AW + 1;
  localparam logic        ONE_TAP = (TAPS == 1);

  typedef enum logic [1:0] {IDLE, WRITE, SEQ} state_e;

  state_e        state_q;
  logic [AW-1:0] wptr_q;
  logic [FW-1:0] fill_q;
  logic          mem_we_q, seq_q, first_q, last_q, primed_q, overrun_q;
  logic [AW-1:0] waddr_q, raddr_q, coef_q;
  logic [15:0]   wdata_q;
`ifdef SEQ_SKID_EN
  logic          skid_vld_q;
  logic [15:0]   skid_q;
  logic          skid_load_d;
`endif

  logic [AW-1:0] wptr_inc_d, seq_start_d, raddr_inc_d, wr_addr_d;
  logic [XW-1:0] wptr_ext_d;
  logic          fill_full_d, seq_last_d, exit_d, go_write_d, drop_d;
  logic [15:0]   wr_data_d;

  // Pointer arithmetic; start address computed in AW+1 bits so that the
  // DEPTH correction never relies on 2^AW wrap.
  always_comb begin
    wptr_inc_d  = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
    wptr_ext_d  = XW'(wptr_inc_d);
    seq_start_d = (wptr_ext_d >= XW'(TAPS)) ? AW'(wptr_ext_d - XW'(TAPS))
                                            : AW'(wptr_ext_d + XW'(DEPTH) - XW'(TAPS));
    raddr_inc_d = (raddr_q == AW'(DEPTH - 1)) ? '0 : raddr_q + AW'(1);
    fill_full_d = (fill_q >= FW'(TAPS - 1));
    seq_last_d  = (coef_q == AW'(TAPS - 1));
    // A write launched from WRITE targets the pointer being advanced now.
    wr_addr_d   = (state_q == WRITE) ? wptr_inc_d : wptr_q;
    exit_d      = ((state_q == WRITE) && !fill_full_d) ||
                  ((state_q == SEQ) && seq_last_d);
  end

  // Write launch and collision handling.
  always_comb begin
    go_write_d = 1'b0;
    wr_data_d  = new_smpl;
    drop_d     = 1'b0;
`ifdef SEQ_SKID_EN
    skid_load_d = 1'b0;
`endif
    case (state_q)
      IDLE: go_write_d = wrt_smpl;
      default: begin
`ifdef SEQ_SKID_EN
        if (exit_d && skid_vld_q) begin
          go_write_d = 1'b1;
          wr_data_d  = skid_q;
          drop_d     = wrt_smpl;
        end else if (exit_d) begin
          // Skid is empty: a request in the exit cycle is written directly.
          go_write_d = wrt_smpl;
        end else if (wrt_smpl) begin
          drop_d      = skid_vld_q;
          skid_load_d = !skid_vld_q;
        end
`else
        drop_d = wrt_smpl;
`endif
      end
    endcase
  end

  // FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      fill_q    <= '0;
      mem_we_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      coef_q    <= '0;
      seq_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      primed_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SEQ_SKID_EN
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      first_q  <= 1'b0;
      if (drop_d) overrun_q <= 1'b1;
`ifdef SEQ_SKID_EN
      if (skid_load_d) begin
        skid_q     <= new_smpl;
        skid_vld_q <= 1'b1;
      end else if (exit_d) begin
        skid_vld_q <= 1'b0;
      end
`endif
      if (go_write_d) begin
        mem_we_q <= 1'b1;
        waddr_q  <= wr_addr_d;
        wdata_q  <= wr_data_d;
      end
      case (state_q)
        IDLE: if (go_write_d) state_q <= WRITE;
        WRITE: begin
          wptr_q <= wptr_inc_d;
          if (fill_q != FW'(TAPS)) fill_q <= fill_q + FW'(1);
          if (fill_full_d) begin
            primed_q <= 1'b1;
            state_q  <= SEQ;
            raddr_q  <= seq_start_d;
            coef_q   <= '0;
            seq_q    <= 1'b1;
            first_q  <= 1'b1;
            last_q   <= ONE_TAP;
          end else begin
            state_q <= go_write_d ? WRITE : IDLE;
          end
        end
        SEQ: begin
          if (seq_last_d) begin
            seq_q   <= 1'b0;
            last_q  <= 1'b0;
            state_q <= go_write_d ? WRITE : IDLE;
          end else begin
            raddr_q <= raddr_inc_d;
            coef_q  <= coef_q + AW'(1);
            last_q  <= ((coef_q + AW'(1)) == AW'(TAPS - 1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_raddr  = raddr_q;
  assign coef_addr  = coef_q;
  assign sequencing = seq_q;
  assign first_tap  = first_q;
  assign last_tap   = last_q;
  assign primed     = primed_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_buf_sequencer.sv
// Bench for fir_buf_sequencer (DEPTH=8, TAPS=5): directed scenarios plus
// random traffic, checked every cycle against a transaction-level model.
module tb_fir_buf_sequencer;

  localparam int unsigned D  = 8;
  localparam int unsigned T  = 5;
  localparam int unsigned AW = 3;
`ifdef SEQ_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, wrt_smpl;
  logic [15:0]   new_smpl;
  logic          mem_we, sequencing, first_tap, last_tap, primed, overrun;
  logic [AW-1:0] mem_waddr, mem_raddr, coef_addr;
  logic [15:0]   mem_wdata;

  fir_buf_sequencer #(.DEPTH(D), .TAPS(T), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .new_smpl(new_smpl),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .coef_addr(coef_addr), .sequencing(sequencing),
    .first_tap(first_tap), .last_tap(last_tap), .primed(primed),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks what phase the block is in (writing, pass tap
  // number) and computes the expected outputs for the next cycle.
  bit          model_valid = 1'b0;
  int          m_wptr, m_fill, m_tap;
  bit          m_skid_full;
  logic [15:0] m_skid;
  bit          e_we, e_seq, e_first, e_last, e_primed, e_ovr;
  int          e_waddr, e_wdata, e_raddr, e_coef;

  always @(posedge clk) begin : model
    bit writing, seqing, done, wr_go;
    logic [15:0] wr_d;
    if (rst) begin
      model_valid = 1'b1;
      m_wptr = 0; m_fill = 0; m_tap = 0; m_skid_full = 1'b0; m_skid = '0;
      e_we = 0; e_seq = 0; e_first = 0; e_last = 0; e_primed = 0; e_ovr = 0;
      e_waddr = 0; e_wdata = 0; e_raddr = 0; e_coef = 0;
    end else if (model_valid) begin
      writing = e_we; seqing = e_seq; done = 0; wr_go = 0; wr_d = new_smpl;
      e_we = 0; e_seq = 0; e_first = 0; e_last = 0;
      if (writing) begin
        m_wptr = (m_wptr + 1) % D;
        if (m_fill < T) m_fill++;
        if (m_fill == T) begin
          e_primed = 1; m_tap = 0; e_seq = 1; e_first = 1; e_last = (T == 1);
          e_raddr = (m_wptr + D - T) % D; e_coef = 0;
        end else done = 1;
      end else if (seqing) begin
        if (m_tap == T - 1) done = 1;
        else begin
          m_tap++; e_seq = 1; e_raddr = (e_raddr + 1) % D; e_coef = m_tap;
          e_last = (m_tap == T - 1);
        end
      end else if (wrt_smpl) wr_go = 1;
      if (done) begin
        if (SKID && m_skid_full) begin
          wr_go = 1; wr_d = m_skid; m_skid_full = 0;
          if (wrt_smpl) e_ovr = 1;
        end else if (SKID && wrt_smpl) wr_go = 1;
        else if (wrt_smpl) e_ovr = 1;
      end else if ((writing || seqing) && wrt_smpl) begin
        if (SKID && !m_skid_full) begin m_skid_full = 1; m_skid = new_smpl; end
        else e_ovr = 1;
      end
      if (wr_go) begin e_we = 1; e_waddr = m_wptr; e_wdata = 32'(wr_d); end
    end
  end

  // Event logs for the directed checks.
  int wl_addr[$], wl_data[$], sl_raddr[$], sl_coef[$], sl_first[$], sl_last[$];

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check_eq("mem_we",     32'(mem_we),     32'(e_we));
      check_eq("mem_waddr",  32'(mem_waddr),  32'(e_waddr));
      check_eq("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
      check_eq("mem_raddr",  32'(mem_raddr),  32'(e_raddr));
      check_eq("coef_addr",  32'(coef_addr),  32'(e_coef));
      check_eq("sequencing", 32'(sequencing), 32'(e_seq));
      check_eq("first_tap",  32'(first_tap),  32'(e_first));
      check_eq("last_tap",   32'(last_tap),   32'(e_last));
      check_eq("primed",     32'(primed),     32'(e_primed));
      check_eq("overrun",    32'(overrun),    32'(e_ovr));
      if (mem_we === 1'b1) begin
        wl_addr.push_back(int'(mem_waddr)); wl_data.push_back(int'(mem_wdata));
      end
      if (sequencing === 1'b1) begin
        sl_raddr.push_back(int'(mem_raddr)); sl_coef.push_back(int'(coef_addr));
        sl_first.push_back(int'(first_tap)); sl_last.push_back(int'(last_tap));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] d);
    wrt_smpl = 1'b1; new_smpl = d;
    @(negedge clk);
    wrt_smpl = 1'b0;
  endtask

  task automatic clear_logs();
    wl_addr.delete(); wl_data.delete(); sl_raddr.delete();
    sl_coef.delete(); sl_first.delete(); sl_last.delete();
  endtask

  initial begin
    int exp_ra[5];
    rst = 1'b1; wrt_smpl = 1'b0; new_smpl = '0;
    tick(2);
    rst = 1'b0;
    check_eq("rst_we",      32'(mem_we),     32'd0);
    check_eq("rst_seq",     32'(sequencing), 32'd0);
    check_eq("rst_primed",  32'(primed),     32'd0);
    check_eq("rst_overrun", 32'(overrun),    32'd0);

    // Four samples: plain writes, no pass.
    clear_logs();
    for (int i = 1; i <= 4; i++) begin pulse(16'(i)); tick(2); end
    tick(2);
    check_eq("fill_nwr", 32'(wl_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (i < wl_addr.size()) check_eq("fill_waddr", 32'(wl_addr[i]), 32'(i));
    check_eq("fill_primed", 32'(primed), 32'd0);
    check_eq("fill_nseq", 32'(sl_raddr.size()), 32'd0);

    // Fifth sample primes and launches the first pass.
    clear_logs();
    pulse(16'h0005); tick(8);
    check_eq("p1_waddr", 32'(wl_addr.size() > 0 ? wl_addr[0] : -1), 32'd4);
    check_eq("p1_primed", 32'(primed), 32'd1);
    check_eq("p1_nseq", 32'(sl_raddr.size()), 32'd5);
    if (sl_raddr.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check_eq("p1_raddr", 32'(sl_raddr[i]), 32'(i));
        check_eq("p1_coef",  32'(sl_coef[i]),  32'(i));
        check_eq("p1_first", 32'(sl_first[i]), 32'(i == 0));
        check_eq("p1_last",  32'(sl_last[i]),  32'(i == 4));
      end
    end

    // Writes 6..10: the last pass wraps around the end of the buffer.
    for (int i = 6; i <= 10; i++) begin
      clear_logs(); pulse(16'(i)); tick(8);
    end
    exp_ra = '{5, 6, 7, 0, 1};
    check_eq("wrap_nseq", 32'(sl_raddr.size()), 32'd5);
    if (sl_raddr.size() == 5)
      for (int i = 0; i < 5; i++) check_eq("wrap_raddr", 32'(sl_raddr[i]), 32'(exp_ra[i]));

    // Collision in the third pass cycle.
    clear_logs();
    pulse(16'h0011); tick(3); pulse(16'h00AB); tick(15);
    check_eq("col_overrun", 32'(overrun), 32'(!SKID));
    check_eq("col_nwr", 32'(wl_addr.size()), SKID ? 32'd2 : 32'd1);
    if (SKID && wl_data.size() == 2) check_eq("col_data", 32'(wl_data[1]), 32'h00AB);

    // Two collisions in one pass: the second one is always lost.
    pulse(16'h0022); tick(3); pulse(16'h00AC); pulse(16'h00AD); tick(20);
    check_eq("col2_overrun", 32'(overrun), 32'd1);

    // Reset in the second pass cycle aborts the pass.
    pulse(16'h0033); tick(2);
    rst = 1'b1; tick(1); rst = 1'b0;
    check_eq("ab_seq",     32'(sequencing), 32'd0);
    check_eq("ab_primed",  32'(primed),     32'd0);
    check_eq("ab_overrun", 32'(overrun),    32'd0);
    clear_logs();
    pulse(16'h0077); tick(3);
    check_eq("ab_nwr", 32'(wl_addr.size()), 32'd1);
    if (wl_addr.size() == 1) check_eq("ab_waddr", 32'(wl_addr[0]), 32'd0);

    // Random traffic, including resets coincident with requests.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      wrt_smpl = ($urandom_range(0, 3) == 0);
      new_smpl = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; wrt_smpl = 1'b0;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
